// File: rtl/sr_latch_driver.sv
// sr_latch_driver: clocked initiator for a cross-coupled NOR SR latch.
// Accepts set/reset commands over valid/ready, drives a fixed-width S or R
// pulse, then confirms the latch through Q/QN synchronisers and reports
// DONE with an error code.
// Optional idle upset monitor: define SR_IDLE_MONITOR_EN. Without it UPSET
// is tied low and no monitor logic exists.
module sr_latch_driver #(
    parameter int PULSE_CYCLES   = 4,   // 2..255
    parameter int TIMEOUT_CYCLES = 16,  // 1..255
    parameter int SYNC_STAGES    = 2    // 2..3
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic       REQ_OP,
    output logic       S,
    output logic       R,
    input  logic       Q,
    input  logic       QN,
    output logic       DONE,
    output logic       ERR,
    output logic [1:0] ERR_CODE,
    output logic       STATE_Q,
    output logic       UPSET
);

    typedef enum logic [1:0] {IDLE, PULSE, WAIT, RESP} state_t;

    localparam logic [1:0] CODE_OK    = 2'b00;
    localparam logic [1:0] CODE_WRONG = 2'b01;
    localparam logic [1:0] CODE_INV   = 2'b10;

    state_t                 state;
    logic                   op;
    logic [7:0]             cnt;     // shared pulse / timeout down-counter
    logic [SYNC_STAGES-1:0] q_sync;
    logic [SYNC_STAGES-1:0] qn_sync;
    logic                   qs;
    logic                   qns;
    logic                   match;
    logic                   invalid;

    assign qs        = q_sync[SYNC_STAGES-1];
    assign qns       = qn_sync[SYNC_STAGES-1];
    assign match     = (qs == op) && (qns == ~op);
    assign invalid   = (qs == qns);
    assign REQ_READY = (state == IDLE);

    // Bring the asynchronous latch outputs into the clock domain
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            q_sync  <= '0;
            qn_sync <= '0;
        end else begin
            q_sync  <= {q_sync[SYNC_STAGES-2:0], Q};
            qn_sync <= {qn_sync[SYNC_STAGES-2:0], QN};
        end
    end

`ifdef SR_IDLE_MONITOR_EN
    // Monitor only trusts Qs/QNs once real samples have filled the chain,
    // otherwise the cleared flops would look like an invalid latch.
    logic [SYNC_STAGES-1:0] sync_fill;
    logic                   flip_prev;
    logic                   inv_prev;
    logic                   inv_fired;
    logic                   mon_on;
    logic                   flip_now;
    logic                   inv_now;
    logic                   flip_fire;
    logic                   inv_fire;

    // Suppressed on a handshake edge so UPSET can never land in PULSE
    assign mon_on    = (state == IDLE) && !REQ_VALID && sync_fill[SYNC_STAGES-1];
    assign flip_now  = mon_on && (qs != STATE_Q) && (qns == ~qs);
    assign inv_now   = mon_on && (qs == qns);
    assign flip_fire = flip_now && flip_prev;
    assign inv_fire  = inv_now && inv_prev && !inv_fired;

    // Track two-cycle persistence of each upset condition
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync_fill <= '0;
            flip_prev <= 1'b0;
            inv_prev  <= 1'b0;
            inv_fired <= 1'b0;
        end else begin
            sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
            flip_prev <= flip_now && !flip_fire;
            inv_prev  <= inv_now;
            inv_fired <= inv_now && (inv_fired || inv_fire);
        end
    end
`else
    assign UPSET = 1'b0;
`endif

    // Command FSM: pulse, wait for confirmation, respond
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= IDLE;
            op       <= 1'b0;
            cnt      <= '0;
            S        <= 1'b0;
            R        <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            ERR_CODE <= CODE_OK;
            STATE_Q  <= 1'b0;
`ifdef SR_IDLE_MONITOR_EN
            UPSET    <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (REQ_VALID) begin
                        op    <= REQ_OP;
                        S     <= REQ_OP;
                        R     <= ~REQ_OP;
                        cnt   <= 8'(PULSE_CYCLES - 1);
                        state <= PULSE;
                    end
                end
                PULSE: begin
                    if (cnt == 8'd0) begin
                        S     <= 1'b0;
                        R     <= 1'b0;
                        cnt   <= 8'(TIMEOUT_CYCLES - 1);
                        state <= WAIT;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                WAIT: begin
                    // success wins over a coincident timeout
                    if (match) begin
                        DONE     <= 1'b1;
                        ERR      <= 1'b0;
                        ERR_CODE <= CODE_OK;
                        STATE_Q  <= op;
                        state    <= RESP;
                    end else if (cnt == 8'd0) begin
                        DONE     <= 1'b1;
                        ERR      <= 1'b1;
                        ERR_CODE <= invalid ? CODE_INV : CODE_WRONG;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RESP: begin
                    ERR      <= 1'b0;
                    ERR_CODE <= CODE_OK;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef SR_IDLE_MONITOR_EN
            UPSET <= flip_fire || inv_fire;
            if (flip_fire) STATE_Q <= qs;
`endif
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: directed scenarios with literal expectations,
// then randomized commands, resets and latch faults checked every cycle
// against a transaction-level timing model.
module tb_sr_latch_driver;

    localparam int P = 4;
    localparam int T = 16;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       REQ_VALID = 1'b0;
    logic       REQ_OP = 1'b0;
    logic       REQ_READY;
    logic       S;
    logic       R;
    logic       Q;
    logic       QN;
    logic       DONE;
    logic       ERR;
    logic [1:0] ERR_CODE;
    logic       STATE_Q;
    logic       UPSET;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 CLK = ~CLK;

    sr_latch_driver #(.PULSE_CYCLES(P), .TIMEOUT_CYCLES(T), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_OP(REQ_OP), .S(S), .R(R), .Q(Q), .QN(QN), .DONE(DONE), .ERR(ERR),
        .ERR_CODE(ERR_CODE), .STATE_Q(STATE_Q), .UPSET(UPSET)
    );

    // Latch: 0 real latch (1 ns), 1 stuck Q=0/QN=1, 2 both low, 3 stuck Q=1/QN=0
    int   fmode = 0;
    logic lat = 1'b0;
    always @(posedge S or posedge R) begin
        #1;
        lat = S ? 1'b1 : 1'b0;
    end
    assign Q  = (fmode == 0) ? lat  : (fmode == 3);
    assign QN = (fmode == 0) ? ~lat : (fmode == 1);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    // Transaction model: edge count e; interval e is the time after edge e.
    int         e = 0;
    bit         m_busy = 1'b0;
    int         m_hs = 0;
    int         m_end = 0;
    bit         m_op = 1'b0;
    bit         m_err = 1'b0;
    logic [1:0] m_code = 2'b00;
    bit         m_stq = 1'b0;

    initial forever begin
        @(posedge CLK);
        e++;
        if (!RST_N) begin
            m_busy = 1'b0;
            m_stq  = 1'b0;
        end else if (m_busy) begin
            if (e == m_end && !m_err) m_stq = m_op;
            if (e == m_end + 1) m_busy = 1'b0;
        end else if (REQ_VALID) begin
            bit fq, fqn;
            m_busy = 1'b1;
            m_hs   = e;
            m_op   = REQ_OP;
            fq  = (fmode == 0) ? REQ_OP  : (fmode == 3);
            fqn = (fmode == 0) ? !REQ_OP : (fmode == 1);
            m_err  = !((fq == REQ_OP) && (fqn == !REQ_OP));
            m_code = !m_err ? 2'b00 : ((fq == fqn) ? 2'b10 : 2'b01);
            // confirmed on the first WAIT cycle, else after the full timeout
            m_end  = m_err ? e + P + T : e + P + 1;
        end
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge CLK);
        if (chk_en) begin
            bit in_pulse, exp_done;
            in_pulse = m_busy && (e < m_hs + P);
            exp_done = m_busy && (e == m_end);
            chk("ready", REQ_READY, !m_busy);
            chk("s", S, in_pulse && m_op);
            chk("r", R, in_pulse && !m_op);
            chk("s_r_excl", S & R, 0);
            chk("done", DONE, exp_done);
            chk("err", ERR, exp_done && m_err);
            chk("err_code", ERR_CODE, exp_done ? m_code : 2'b00);
`ifndef SR_IDLE_MONITOR_EN
            // monitor can legitimately rewrite STATE_Q when enabled
            chk("state_q", STATE_Q, m_stq);
            chk("upset", UPSET, 0);
`endif
        end
    end

    // One command with literal expectations on DONE offset and outcome
    task automatic directed(input bit op, input int mode, input int exp_off,
                            input bit exp_err, input logic [1:0] exp_code, input bit exp_stq);
        int off = 0;
        int s_cnt = 0;
        int r_cnt = 0;
        bit seen = 1'b0;
        fmode = mode;
        repeat (3) @(posedge CLK);
        #1;
        REQ_VALID = 1'b1;
        REQ_OP = op;
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        while (!seen && off < 40) begin
            @(negedge CLK);
            if (S) s_cnt++;
            if (R) r_cnt++;
            if (DONE) begin
                seen = 1'b1;
                chk("dir_done_offset", off, exp_off);
                chk("dir_err", ERR, exp_err);
                chk("dir_err_code", ERR_CODE, exp_code);
                chk("dir_state_q", STATE_Q, exp_stq);
            end else begin
                off++;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL dir_done_wait t=%0t no DONE within 40 cycles", $time);
        end
        chk("dir_pulse_width", op ? s_cnt : r_cnt, P);
        chk("dir_other_drive", op ? r_cnt : s_cnt, 0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog t=%0t simulation did not finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        chk_en = 1'b1;
        chk("rst_ready", REQ_READY, 1);
        chk("rst_outputs", {S, R, DONE, ERR, ERR_CODE, STATE_Q, UPSET}, 0);
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;

        directed(1'b1, 0, P + 1, 1'b0, 2'b00, 1'b1);       // set
        directed(1'b0, 0, P + 1, 1'b0, 2'b00, 1'b0);       // reset
        directed(1'b1, 1, 20, 1'b1, 2'b01, 1'b0);          // stuck latch
        directed(1'b0, 2, 20, 1'b1, 2'b10, 1'b0);          // Q==QN
        directed(1'b1, 0, 5, 1'b0, 2'b00, 1'b1);           // set again
        directed(1'b1, 0, 5, 1'b0, 2'b00, 1'b1);           // repeated set

        // reset in the middle of a pulse: no DONE for the aborted command
        REQ_VALID = 1'b1;
        REQ_OP = 1'b0;
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("abort_r_low", R, 0);
        chk("abort_ready", REQ_READY, 1);
        #1;
        RST_N = 1'b1;
        dones = 0;
        repeat (30) begin
            @(negedge CLK);
            if (DONE) dones++;
        end
        chk("abort_no_done", dones, 0);
        @(posedge CLK);
        #1;
        directed(1'b0, 0, 5, 1'b0, 2'b00, 1'b0);

        // randomized traffic, faults and resets
        for (int i = 0; i < 3000; i++) begin
            @(posedge CLK);
            #1;
            RST_N = ($urandom_range(0, 79) != 0);
            if (!m_busy && $urandom_range(0, 3) == 0) fmode = $urandom_range(0, 3);
            REQ_VALID = ($urandom_range(0, 2) != 0);
            REQ_OP = $urandom_range(0, 1);
        end
        REQ_VALID = 1'b0;
        RST_N = 1'b1;
        for (int i = 0; i < 40 && m_busy; i++) @(posedge CLK);
        @(negedge CLK);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
